// File: rtl/mem_arbiter.sv
// Two-port round-robin sequencer in front of the MAR/MDR/RAM memory block.
// Latches the winning request, then steps the memory strobes and acknowledges.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  owner,
  output logic                  busy,
  output logic [15:0]           bus_out,
  output logic                  bus_drv,
  output logic                  mar_load,
  output logic                  mdr_load_bus,
  output logic                  mdr_load_low,
  output logic                  ram_write,
  output logic                  mdr_en
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    WRITE,
    RFETCH,
    RCAP,
    DONE
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic                  last_grant;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  gnt;
  logic                  gnt_port;
  logic [ADDR_WIDTH-1:0] gnt_addr;

  always_comb begin
    gnt      = req0 | req1;
    gnt_port = (req0 && req1) ? ~last_grant : req1;
    gnt_addr = gnt_port ? addr1 : addr0;
    state_d  = state_q;
    case (state_q)
      IDLE:    if (gnt) state_d = ADDR;
      ADDR:    state_d = we_q ? WDATA : RFETCH;
      WDATA:   state_d = WRITE;
      WRITE:   state_d = DONE;
      RFETCH:  state_d = RCAP;
      RCAP:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each strobe is aligned with
  // its state; ADDR is only entered from IDLE, so its bus value comes from the
  // grant mux rather than from addr_q, which loads on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant   <= 1'b1;
      owner        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata        <= '0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      busy         <= 1'b0;
      bus_out      <= '0;
      bus_drv      <= 1'b0;
      mar_load     <= 1'b0;
      mdr_load_bus <= 1'b0;
      mdr_load_low <= 1'b0;
      ram_write    <= 1'b0;
      mdr_en       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && gnt) begin
        we_q       <= gnt_port ? we1 : we0;
        addr_q     <= gnt_addr;
        wdata_q    <= gnt_port ? wdata1 : wdata0;
        owner      <= gnt_port;
        last_grant <= gnt_port;
      end
      if (state_q == RCAP) rdata <= mem_rdata;

      busy         <= (state_d != IDLE);
      bus_drv      <= (state_d == ADDR) || (state_d == WDATA);
      mar_load     <= (state_d == ADDR);
      mdr_load_bus <= (state_d == WDATA);
      ram_write    <= (state_d == WRITE);
      mdr_load_low <= (state_d == RFETCH);
      mdr_en       <= (state_d == RCAP);
      ack0         <= (state_d == DONE) && !owner;
      ack1         <= (state_d == DONE) && owner;
      case (state_d)
        ADDR:    bus_out <= 16'(gnt_addr);
        WDATA:   bus_out <= 16'(wdata_q);
        default: bus_out <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter with a small memory environment
// and a transaction-level reference model (expected RAM contents and rdata).
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int P_IDLE = 0, P_ADDR = 1, P_WDATA = 2, P_WRITE = 3,
                 P_RFETCH = 4, P_RCAP = 5, P_DONE = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [15:0] addr0 = '0, addr1 = '0;
  logic [7:0]  wdata0 = '0, wdata1 = '0;
  logic [7:0]  mem_rdata;
  logic        ack0, ack1, owner, busy, bus_drv;
  logic        mar_load, mdr_load_bus, mdr_load_low, ram_write, mdr_en;
  logic [7:0]  rdata;
  logic [15:0] bus_out;

  mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .mem_rdata(mem_rdata),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .owner(owner), .busy(busy),
    .bus_out(bus_out), .bus_drv(bus_drv), .mar_load(mar_load),
    .mdr_load_bus(mdr_load_bus), .mdr_load_low(mdr_load_low),
    .ram_write(ram_write), .mdr_en(mdr_en)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory block stand-in: MAR, MDR and a 64K x 8 RAM driven by the strobes.
  logic [7:0]  ram [0:65535];
  logic [15:0] mar = '0;
  logic [7:0]  mdr = '0;
  always @(posedge clk) begin
    if (mar_load)     mar <= bus_out;
    if (mdr_load_bus) mdr <= bus_out[7:0];
    if (ram_write)    ram[mar] <= mdr;
    if (mdr_load_low) mdr <= ram[mar];
  end
  assign mem_rdata = mdr;

  // Reference model: what each address should hold and what rdata should show.
  logic [7:0]  ref_mem [logic [15:0]];
  logic [7:0]  exp_rdata = '0;
  int          tests = 0;
  int          fails = 0;
  int unsigned last_ack_cyc = 0;

  function automatic logic [7:0] exp_read(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {mar_load,mdr_load_bus,mdr_load_low,ram_write,mdr_en,bus_drv,ack0,ack1,busy}.
  function automatic logic [8:0] exp_vec(input int ph, input bit port);
    logic [8:0] e;
    e = '0;
    case (ph)
      P_ADDR:   begin e[8] = 1'b1; e[3] = 1'b1; end
      P_WDATA:  begin e[7] = 1'b1; e[3] = 1'b1; end
      P_WRITE:  e[5] = 1'b1;
      P_RFETCH: e[6] = 1'b1;
      P_RCAP:   e[4] = 1'b1;
      P_DONE:   begin e[2] = !port; e[1] = port; end
      default:  e = '0;
    endcase
    e[0] = (ph != P_IDLE);
    return e;
  endfunction

  task automatic check_phase(input string tag, input int ph, input bit port,
                             input logic [15:0] exp_bus);
    chk({tag, "/strobes"},
        32'({mar_load, mdr_load_bus, mdr_load_low, ram_write, mdr_en, bus_drv, ack0, ack1, busy}),
        32'(exp_vec(ph, port)));
    chk({tag, "/bus_out"}, 32'(bus_out), 32'(exp_bus));
  endtask

  // One transaction on one port; called at a negedge. hold keeps req high after
  // ack, gap checks the ack lands 5 cycles after the previous one, perturb
  // disturbs port 0's inputs during WDATA.
  task automatic txn(input string tag, input bit port, input bit we,
                     input logic [15:0] addr, input logic [7:0] wd,
                     input bit hold, input bit gap, input bit perturb);
    int guard;
    guard = 0;
    while (busy && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "/idle"}, 32'(busy), 32'(0));
    if (port) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd; end
    else      begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd; end
    @(negedge clk);
    check_phase({tag, "/addr"}, P_ADDR, port, addr);
    chk({tag, "/owner"}, 32'(owner), 32'(port));
    @(negedge clk);
    check_phase({tag, we ? "/wdata" : "/rfetch"}, we ? P_WDATA : P_RFETCH, port,
                we ? {8'h00, wd} : 16'h0000);
    if (perturb) begin
      addr0 = addr ^ 16'h0F0F;
      req0  = 1'b0;
    end
    @(negedge clk);
    check_phase({tag, we ? "/write" : "/rcap"}, we ? P_WRITE : P_RCAP, port, 16'h0000);
    @(negedge clk);
    if (we) ref_mem[addr] = wd;
    else    exp_rdata = exp_read(addr);
    check_phase({tag, "/done"}, P_DONE, port, 16'h0000);
    chk({tag, "/rdata"}, 32'(rdata), 32'(exp_rdata));
    if (gap) chk({tag, "/gap"}, cyc - last_ack_cyc, 32'd5);
    last_ack_cyc = cyc;
    if (!hold) begin
      if (port) req1 = 1'b0;
      else      req0 = 1'b0;
    end
  endtask

  initial begin
    int unsigned start;
    int          ack_port [$];
    int unsigned ack_cyc [$];
    logic [15:0] a;
    bit          p, w;
    bit          seen;

    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;

    // Reset values, asynchronously applied.
    #1;
    check_phase("reset", P_IDLE, 1'b0, 16'h0000);
    chk("reset/owner", 32'(owner), 32'(0));
    chk("reset/rdata", 32'(rdata), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Contention straight after reset: grants alternate starting at port 0.
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0200; wdata0 = 8'h22;
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0201; wdata1 = 8'h33;
    start = cyc;
    for (int i = 0; i < 30 && ack_port.size() < 4; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        chk("contend/single_ack", 32'(ack0 & ack1), 32'(0));
        ack_port.push_back(ack1 ? 1 : 0);
        ack_cyc.push_back(cyc);
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chk("contend/acks", 32'(ack_port.size()), 32'd4);
    foreach (ack_port[i]) begin
      chk($sformatf("contend/port%0d", i), 32'(ack_port[i]), 32'(i % 2));
      chk($sformatf("contend/cycle%0d", i), ack_cyc[i], start + 4 + 5 * i);
    end
    ref_mem[16'h0200] = 8'h22;
    ref_mem[16'h0201] = 8'h33;
    if (ack_cyc.size() > 0) last_ack_cyc = ack_cyc[ack_cyc.size() - 1];

    txn("p0_write", 1'b0, 1'b1, 16'h0010, 8'h5A, 1'b0, 1'b0, 1'b0);
    txn("p1_read",  1'b1, 1'b0, 16'h0010, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("p1_read/value", 32'(rdata), 32'h5A);

    // Port 1 alone: four back-to-back reads with req held high.
    txn("b2b0", 1'b1, 1'b0, 16'h0200, 8'h00, 1'b1, 1'b0, 1'b0);
    txn("b2b1", 1'b1, 1'b0, 16'h0201, 8'h00, 1'b1, 1'b1, 1'b0);
    txn("b2b2", 1'b1, 1'b0, 16'h0010, 8'h00, 1'b1, 1'b1, 1'b0);
    txn("b2b3", 1'b1, 1'b0, 16'h0200, 8'h00, 1'b0, 1'b1, 1'b0);

    // Address change and req drop during WDATA must not disturb the write.
    txn("perturb", 1'b0, 1'b1, 16'h0300, 8'hC3, 1'b0, 1'b0, 1'b1);
    txn("perturb_rd_latched", 1'b1, 1'b0, 16'h0300, 8'h00, 1'b0, 1'b0, 1'b0);
    txn("perturb_rd_other",   1'b1, 1'b0, 16'h0C0F, 8'h00, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      p = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = 16'h0400 + 16'($urandom_range(0, 7));
      txn($sformatf("rand%0d", n), p, w, a, 8'($urandom), 1'b0, 1'b0, 1'b0);
    end

    // Reset during RFETCH, then contention must go to port 0 again.
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0010;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid/rfetch", 32'(mdr_load_low), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    check_phase("rst_mid", P_IDLE, 1'b0, 16'h0000);
    chk("rst_mid/rdata", 32'(rdata), 32'(0));
    chk("rst_mid/owner", 32'(owner), 32'(0));
    exp_rdata = 8'h00;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0500; wdata1 = 8'hEE;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_phase("rst_after/addr", P_ADDR, 1'b0, 16'h0010);
    chk("rst_after/owner", 32'(owner), 32'(0));
    req0 = 1'b0;
    req1 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      if (ack0 || ack1) seen = 1'b1;
    end
    chk("rst_after/ack0", 32'({ack0, ack1}), 32'b10);
    exp_rdata = exp_read(16'h0010);
    chk("rst_after/rdata", 32'(rdata), 32'(exp_rdata));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory access sequencer placed between the requesters and the shared `memory` block (MAR/MDR/RAM) on the 16-bit system bus. Port 0 serves the CPU data path and port 1 serves the program loader/debug port. The block arbitrates round-robin between the two ports and latches the winning request. It then sequences the MAR load, MDR load, RAM write and MDR bus-enable strobes, and returns a one-cycle acknowledge plus read data.

## Interface
- `ADDR_WIDTH`, 16: address width; zero-extended to 16 bits on the bus.
- `DATA_WIDTH`, 8: data width; zero-extended to 16 bits on the bus.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req0`, `req1`  in  1  access request, port 0 / port 1.
- `we0`, `we1`  in  1  1 = write, 0 = read; sampled at grant.
- `addr0`, `addr1`  in  ADDR_WIDTH  access address; sampled at grant.
- `wdata0`, `wdata1`  in  DATA_WIDTH  write data; sampled at grant.
- `mem_rdata`  in  DATA_WIDTH  MDR output from memory.
- `ack0`, `ack1`  out  1  one-cycle completion pulse per port.
- `rdata`  out  DATA_WIDTH  last read result, shared by both ports.
- `owner`  out  1  port owning the current or most recent transaction.
- `busy`  out  1  high in every state except IDLE.
- `bus_out`  out  16  value driven toward the system bus.
- `bus_drv`  out  1  `bus_out` valid; the bus mux selects it when high.
- `mar_load`, `mdr_load_bus`, `mdr_load_low`, `ram_write`, `mdr_en`  out  1  memory control strobes.

## Operation
- FSM states: IDLE, ADDR, WDATA, WRITE, RFETCH, RCAP, DONE. Outputs are Moore-decoded from state and latched registers.
- **IDLE**
  - No request: remain in IDLE.
  - One request: grant that port.
  - Both requesting: grant the port that is not `last_grant`.
  - On grant, latch `we`, `addr` and `wdata` into internal registers, set `owner` and `last_grant` to the granted port, and go to ADDR.
- **ADDR**
  - `bus_out = {0, addr_q}`, `bus_drv=1`, `mar_load=1`.
  - Next state is WDATA if `we_q`, otherwise RFETCH.
- **WDATA**: `bus_out = {0, wdata_q}`, `bus_drv=1`, `mdr_load_bus=1`; go to WRITE.
- **WRITE**: `ram_write=1`; go to DONE.
- **RFETCH**: `mdr_load_low=1` (RAM byte into MDR); go to RCAP.
- **RCAP**: `mdr_en=1`; `rdata <= mem_rdata` at the end of the cycle; go to DONE.
- **DONE**: `ack[owner]=1`; go to IDLE unconditionally.
- In every state not listed above, all strobes, `bus_drv` and `bus_out` are 0. At most one strobe is high per cycle.
- Latched values are fixed for the whole transaction. Changing or dropping `req`/`addr`/`wdata` after grant does not abort or alter the access, and `ack` still pulses.
- `rdata` holds its value until the next RCAP. Write transactions do not modify it.
- A port that keeps `req` high after its `ack` is treated as a new request in the following IDLE cycle.

## Timing
- Reset (asynchronous, `rst=0`): state IDLE, `last_grant=1` (port 0 wins the first contention), `owner=0`, `rdata=0`. `ack0`, `ack1`, `busy`, `bus_drv`, `bus_out` and all strobes are 0.
- Reset mid-transaction aborts the access immediately. The RAM contents depend on whether the WRITE cycle had already completed.
- Grant happens at edge k, with the request seen in IDLE during cycle k-1.
  - Write: ADDR in cycle k, WDATA k+1, WRITE k+2, DONE/ack k+3.
  - Read: ADDR in cycle k, RFETCH k+1, RCAP k+2, DONE/ack k+3. `rdata` is valid in the `ack` cycle.
- Request-to-ack latency is 5 cycles counting the IDLE cycle. Sustained throughput is one access per 5 cycles.
- Requester protocol: hold `req` until `ack`; deassert on the edge ending the `ack` cycle. A new request may be raised in the next cycle.
- Round-robin guarantees that a continuously requesting port waits at most one foreign transaction.

## Test plan
- **Port 0 write:** `addr0=0x0010`, `wdata0=0x5A`, `we0=1`. Expect `bus_out=0x0010` with `mar_load` in cycle k, `bus_out=0x005A` with `mdr_load_bus` in k+1, `ram_write` in k+2, `ack0` in k+3. `ack1` stays 0.
- **Port 1 read-back:** read `0x0010`. Expect `mdr_load_low` in k+1, `mdr_en` in k+2, `ack1` in k+3 with `rdata=0x5A`, and `owner=1`.
- **Contention after reset:** `req0` and `req1` both held high. Grants alternate 0,1,0,1. Acks are spaced exactly 5 cycles apart, and neither port gets two consecutive grants.
- **Single requester:** port 1 issues four back-to-back reads with no port 0 activity. Every request is granted, with acks 5 cycles apart.
- **Mid-transaction changes:** change `addr0` and drop `req0` during WDATA. The write still completes to the latched address and `ack0` still pulses.
- **Reset during RFETCH:** assert `rst=0`. All outputs go to 0 and the FSM goes to IDLE immediately, with no clock needed. `rdata=0`. After release, a contended request is granted to port 0.
